// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD sequencer: state encoding and default sizing.
package gcd_pkg;

   localparam int GCD_WIDTH    = 32;
   localparam int GCD_MAX_ITER = 1024;
   localparam int GCD_CNT_W    = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } gcd_state_t;

endpackage

// File: rtl/gcd_seq_if.sv
// Core <-> GCD coprocessor handshake: start/operands in, status/result out.
interface gcd_seq_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 32
);
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             busy;
   logic             done;
   logic             err;
   logic [WIDTH-1:0] result;
   logic [CNT_W-1:0] iter_count;

   // Core side: issues requests, observes status.
   modport master (
      output start, a_in, b_in,
      input  busy, done, err, result, iter_count
   );

   // Coprocessor side.
   modport slave (
      input  start, a_in, b_in,
      output busy, done, err, result, iter_count
   );
endinterface

// File: rtl/gcd_diff_path.sv
// Shared difference datapath: unsigned compare, (larger, smaller) operand
// mux and the single subtractor. Purely combinational.
module gcd_diff_path #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             gt,
   output logic             eq,
   output logic             x_zero,
   output logic             y_zero,
   output logic [WIDTH-1:0] diff
);
   logic [WIDTH-1:0] larger;
   logic [WIDTH-1:0] smaller;

   assign gt     = (x > y);
   assign eq     = (x == y);
   assign x_zero = (x == '0);
   assign y_zero = (y == '0);

   // Steering the larger operand to the minuend keeps diff non-negative.
   assign larger  = gt ? x : y;
   assign smaller = gt ? y : x;
   assign diff    = larger - smaller;
endmodule

// File: rtl/gcd_seq.sv
// GCD coprocessor: repeated-subtraction sequencer with step counter and
// timeout so pathological operands cannot stall the core indefinitely.
module gcd_seq
   import gcd_pkg::*;
#(
   parameter int WIDTH    = GCD_WIDTH,
   parameter int MAX_ITER = GCD_MAX_ITER,
   parameter int CNT_W    = GCD_CNT_W
) (
   input  logic      clk,
   input  logic      rst,
   gcd_seq_if.slave  bus
);
   gcd_state_t       state;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic [WIDTH-1:0] result_q;
   logic [CNT_W-1:0] iter_q;
   logic             busy_q;
   logic             done_q;
   logic             err_q;

   logic             gt;
   logic             eq;
   logic             x_zero;
   logic             y_zero;
   logic [WIDTH-1:0] diff;

   gcd_diff_path #(.WIDTH(WIDTH)) u_diff (
      .x      (x),
      .y      (y),
      .gt     (gt),
      .eq     (eq),
      .x_zero (x_zero),
      .y_zero (y_zero),
      .diff   (diff)
   );

   // Sequencer FSM with registered status/result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         x        <= '0;
         y        <= '0;
         result_q <= '0;
         iter_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  x      <= bus.a_in;
                  y      <= bus.b_in;
                  iter_q <= '0;
                  err_q  <= 1'b0;
                  busy_q <= 1'b1;
                  state  <= S_RUN;
               end
            end
            S_RUN: begin
               if (eq || x_zero || y_zero) begin
                  result_q <= x_zero ? y : x;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state    <= S_DONE;
               end else if (iter_q == CNT_W'(MAX_ITER)) begin
                  // Step budget exhausted: flag it and return no result.
                  err_q    <= 1'b1;
                  result_q <= '0;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state    <= S_DONE;
               end else begin
                  if (gt) x <= diff;
                  else    y <= diff;
                  iter_q <= iter_q + CNT_W'(1);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;
   assign bus.result     = result_q;
   assign bus.iter_count = iter_q;
endmodule
